// File: rtl/psum_collector_pkg.sv
// ---------------------------------------------------------------------------
// psum_collector_pkg
//
// Shared definitions for the MMU output-side partial-sum collector.
//   DEF_SYS_COL / DEF_DATA_WIDTH / DEF_FIFO_DEPTH : default build geometry
//   psum_t : one accumulator-wide partial sum (2 * DATA_WIDTH bits)
//   row_t  : one buffered output row, all columns plus the tile-last tag
// ---------------------------------------------------------------------------
package psum_collector_pkg;

    localparam int DEF_SYS_COL    = 16;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_PSUM_WIDTH = 2 * DEF_DATA_WIDTH;
    localparam int DEF_FIFO_DEPTH = 8;

    typedef logic [DEF_PSUM_WIDTH-1:0] psum_t;

    typedef struct packed {
        psum_t [DEF_SYS_COL-1:0] row;
        logic                    last;
    } row_t;

endpackage

// File: rtl/psum_collector_if.sv
// ---------------------------------------------------------------------------
// psum_collector_if
//
// Row output stream from the collector to the result writer.
//   out_valid : FIFO head row is valid
//   out_ready : consumer accepts the head row this cycle
//   out_data  : head row, one partial sum per array column
//   out_last  : head row closes a tile
// Modports: master = collector (drives the row), slave = result writer.
// ---------------------------------------------------------------------------
interface psum_collector_if
    import psum_collector_pkg::*;
#(
    parameter int SYS_COL    = DEF_SYS_COL,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    localparam int PSUM_WIDTH = 2 * DATA_WIDTH;

    logic                  out_valid;
    logic                  out_ready;
    logic [PSUM_WIDTH-1:0] out_data [0:SYS_COL-1];
    logic                  out_last;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);

endinterface

// File: rtl/psum_collector_fifo.sv
// ---------------------------------------------------------------------------
// psum_fifo
//
// Synchronous first-word-fall-through FIFO. Full/empty come from read and
// write pointers carrying one extra wrap bit.
//   clk, rstn  : clock, synchronous active-low reset (pointers only)
//   push       : write push_data (caller guarantees !full || pop)
//   push_data  : entry to write
//   pop        : retire the head entry (caller guarantees !empty)
//   head       : current head entry, valid whenever !empty
//   empty/full : occupancy flags
//   count      : occupied entries, 0..DEPTH
// ---------------------------------------------------------------------------
module psum_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide
    // which entries are meaningful, and a reset here would forbid RAM mapping.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/psum_collector.sv
// ---------------------------------------------------------------------------
// psum_collector
//
// Collects the column-skewed partial sums leaving the systolic array's bottom
// row, re-aligns them into whole rows, tags tile boundaries and buffers rows
// for the result writer. The array cannot stall, so overflow drops the row
// and raises a sticky flag instead of back-pressuring.
//   clk, rstn  : clock, synchronous active-low reset
//   psum_in    : per-column partial sums, column c lags column 0 by c cycles
//   en_in      : per-column qualifiers, skewed like psum_in
//   cfg_rows   : rows per tile (0 = every row is last), sampled on each push
//   row_bus    : output row stream (valid/ready, data, last)
//   fifo_count : buffered rows
//   overflow   : sticky, a complete row was dropped because the FIFO was full
//   skew_err   : sticky, re-aligned enables disagreed across columns
// Build option: define PSUM_COLLECT_RELU_EN to clamp negative sums to zero
// as rows are written into the FIFO.
// ---------------------------------------------------------------------------
module psum_collector
    import psum_collector_pkg::*;
#(
    parameter int SYS_COL    = DEF_SYS_COL,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int PSUM_WIDTH = 2 * DATA_WIDTH,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [PSUM_WIDTH-1:0] psum_in [0:SYS_COL-1],
    input  logic [SYS_COL-1:0]    en_in,
    input  logic [15:0]           cfg_rows,
    psum_collector_if.master      row_bus,
    output logic [CW-1:0]         fifo_count,
    output logic                  overflow,
    output logic                  skew_err
);
    localparam int ROW_W = SYS_COL * PSUM_WIDTH + 1;

    logic [PSUM_WIDTH-1:0] aligned_psum [SYS_COL];
    logic [SYS_COL-1:0]    aligned_en;

    // De-skew: column c waits SYS_COL-1-c cycles so every column of a row
    // lines up with the last column, which passes straight through.
    for (genvar c = 0; c < SYS_COL; c++) begin : g_col
        localparam int DEPTH = SYS_COL - 1 - c;
        if (DEPTH == 0) begin : g_direct
            assign aligned_psum[c] = psum_in[c];
            assign aligned_en[c]   = en_in[c];
        end else begin : g_delay
            logic [PSUM_WIDTH-1:0] psum_sr [DEPTH];
            logic [DEPTH-1:0]      en_sr;

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    en_sr <= '0;
                end else begin
                    en_sr[0] <= en_in[c];
                    for (int i = 1; i < DEPTH; i++) en_sr[i] <= en_sr[i-1];
                end
            end

            always_ff @(posedge clk) begin
                psum_sr[0] <= psum_in[c];
                for (int i = 1; i < DEPTH; i++) psum_sr[i] <= psum_sr[i-1];
            end

            assign aligned_psum[c] = psum_sr[DEPTH-1];
            assign aligned_en[c]   = en_sr[DEPTH-1];
        end
    end

    logic             row_full;
    logic             row_mixed;
    logic             row_last;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic [15:0]      row_cnt;
    logic [ROW_W-1:0] push_row;
    logic [ROW_W-1:0] head_row;

    assign row_full  = &aligned_en;
    assign row_mixed = (|aligned_en) && !row_full;
    assign pop       = row_bus.out_valid && row_bus.out_ready;
    // A slot freed by a same-cycle pop can be refilled immediately.
    assign push      = row_full && (!fifo_full || pop);
    assign row_last  = (cfg_rows == 16'd0) || (row_cnt == cfg_rows - 16'd1);

    // NOTE: the packed row gets a full default before the per-column writes
    // so no bit is left unassigned on any path and no latch is inferred.
    always_comb begin
        push_row = '0;
        for (int c = 0; c < SYS_COL; c++) begin
`ifdef PSUM_COLLECT_RELU_EN
            push_row[c*PSUM_WIDTH +: PSUM_WIDTH] =
                aligned_psum[c][PSUM_WIDTH-1] ? {PSUM_WIDTH{1'b0}} : aligned_psum[c];
`else
            push_row[c*PSUM_WIDTH +: PSUM_WIDTH] = aligned_psum[c];
`endif
        end
        push_row[ROW_W-1] = row_last;
    end

    // Tile row counter and sticky error flags; dropped rows never advance
    // the counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            row_cnt  <= '0;
            overflow <= 1'b0;
            skew_err <= 1'b0;
        end else begin
            if (push)              row_cnt  <= row_last ? 16'd0 : row_cnt + 16'd1;
            if (row_full && !push) overflow <= 1'b1;
            if (row_mixed)         skew_err <= 1'b1;
        end
    end

    psum_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (push_row),
        .pop       (pop),
        .head      (head_row),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    // Head fields read as zero while nothing is buffered so the unreset
    // storage never shows through after reset.
    assign row_bus.out_valid = !fifo_empty;
    assign row_bus.out_last  = !fifo_empty && head_row[ROW_W-1];

    for (genvar c = 0; c < SYS_COL; c++) begin : g_out
        assign row_bus.out_data[c] = fifo_empty ? {PSUM_WIDTH{1'b0}}
                                                : head_row[c*PSUM_WIDTH +: PSUM_WIDTH];
    end

endmodule

// File: tb/tb_psum_collector.sv
// ---------------------------------------------------------------------------
// tb_psum_collector
//
// Self-checking bench for psum_collector. Stimulus rows are written into a
// per-cycle schedule (skewed enables and data, consumer ready). A reference
// model holds the expected FIFO contents as a queue of whole rows, applies
// the tile/overflow/skew rules at each row's alignment cycle, and every
// cycle's outputs are compared against it on the falling clock edge.
// Honours PSUM_COLLECT_RELU_EN when building the expected row values.
// ---------------------------------------------------------------------------
module tb_psum_collector;
    import psum_collector_pkg::*;

    localparam int SYS_COL    = DEF_SYS_COL;
    localparam int DATA_WIDTH = DEF_DATA_WIDTH;
    localparam int FIFO_DEPTH = DEF_FIFO_DEPTH;
    localparam int PW         = 2 * DATA_WIDTH;
    localparam int MAXC       = 4096;

    logic                          clk = 1'b0;
    logic                          rstn = 1'b0;
    logic [PW-1:0]                 psum_in [0:SYS_COL-1];
    logic [SYS_COL-1:0]            en_in;
    logic [15:0]                   cfg_rows;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow;
    logic                          skew_err;

    psum_collector_if #(.SYS_COL(SYS_COL), .DATA_WIDTH(DATA_WIDTH)) row_bus ();

    psum_collector #(
        .SYS_COL    (SYS_COL),
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .psum_in    (psum_in),
        .en_in      (en_in),
        .cfg_rows   (cfg_rows),
        .row_bus    (row_bus),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .skew_err   (skew_err)
    );

    always #5 clk = ~clk;

    // Stimulus schedule, indexed by absolute cycle.
    logic [SYS_COL-1:0] sch_en  [MAXC];
    psum_t              sch_d   [MAXC][SYS_COL];
    bit                 sch_rdy [MAXC];
    int                 arr_kind [MAXC];   // 0 none, 1 complete row, 2 broken row
    row_t               arr_row  [MAXC];

    // Reference model state.
    row_t  exp_q[$];
    bit    exp_ovf;
    bit    exp_skew;
    int    tile_pos;

    psum_t row_buf [SYS_COL];
    int    cyc;
    bit    rst_now;
    int    n_checks;
    int    n_fail;

    function automatic psum_t ref_val(psum_t v);
`ifdef PSUM_COLLECT_RELU_EN
        return ($signed(v) < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_row();
        for (int c = 0; c < SYS_COL; c++) row_buf[c] = $urandom();
    endtask

    // Schedule row_buf starting at cycle 'start'; column 'drop' (if >= 0) is
    // withheld so the row arrives broken.
    task automatic launch(input int start, input int drop);
        for (int c = 0; c < SYS_COL; c++) begin
            sch_en[start+c][c] = (c != drop);
            sch_d[start+c][c]  = row_buf[c];
            arr_row[start+SYS_COL-1].row[c] = ref_val(row_buf[c]);
        end
        arr_kind[start+SYS_COL-1] = (drop < 0) ? 1 : 2;
    endtask

    task automatic set_rdy(input int from, input int len, input bit val);
        for (int k = from; k < from + len; k++) sch_rdy[k] = val;
    endtask

    task automatic check_outputs();
        check($sformatf("valid@%0d", cyc), row_bus.out_valid, exp_q.size() > 0);
        check($sformatf("count@%0d", cyc), fifo_count, exp_q.size());
        check($sformatf("overflow@%0d", cyc), overflow, exp_ovf);
        check($sformatf("skew_err@%0d", cyc), skew_err, exp_skew);
        if (exp_q.size() > 0) begin
            check($sformatf("last@%0d", cyc), row_bus.out_last, exp_q[0].last);
            for (int c = 0; c < SYS_COL; c++)
                check($sformatf("data[%0d]@%0d", c, cyc), row_bus.out_data[c], exp_q[0].row[c]);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_last"}, row_bus.out_last, 1'b0);
        for (int c = 0; c < SYS_COL; c++)
            check($sformatf("%s_data[%0d]", tag, c), row_bus.out_data[c], '0);
    endtask

    // What the clock edge closing cycle 'cyc' must do to the buffered rows.
    task automatic update_model();
        bit   popping;
        bit   accept;
        int   cr;
        row_t e;
        if (rst_now) begin
            exp_q.delete();
            exp_ovf  = 1'b0;
            exp_skew = 1'b0;
            tile_pos = 0;
            return;
        end
        popping = (exp_q.size() > 0) && row_bus.out_ready;
        accept  = 1'b0;
        cr      = int'(cfg_rows);
        if (arr_kind[cyc] == 2) begin
            exp_skew = 1'b1;
        end else if (arr_kind[cyc] == 1) begin
            if (exp_q.size() < FIFO_DEPTH || popping) begin
                accept = 1'b1;
                e      = arr_row[cyc];
                e.last = (cr == 0) || (tile_pos == cr - 1);
                tile_pos = e.last ? 0 : tile_pos + 1;
            end else begin
                exp_ovf = 1'b1;
            end
        end
        if (popping) void'(exp_q.pop_front());
        if (accept)  exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_now) begin
            for (int k = cyc; k < MAXC; k++) begin
                sch_en[k]   = '0;
                arr_kind[k] = 0;
            end
        end
        rstn              = !rst_now;
        en_in             = sch_en[cyc];
        row_bus.out_ready = sch_rdy[cyc];
        for (int c = 0; c < SYS_COL; c++) psum_in[c] = sch_d[cyc][c];
        @(negedge clk);
        check_outputs();
        update_model();
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic random_round(input int ncyc, input int cfg);
        int s;
        s = cyc;
        cfg_rows = 16'(cfg);
        for (int k = 0; k < ncyc; k++) begin
            sch_rdy[s+k] = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) < 6) begin
                rand_row();
                launch(s + k, ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, SYS_COL-1)) : -1);
            end
        end
        run(ncyc + SYS_COL + 4 * FIFO_DEPTH);
    endtask

    initial begin
        int s;
        for (int k = 0; k < MAXC; k++) begin
            sch_en[k]   = '0;
            sch_rdy[k]  = 1'b1;
            arr_kind[k] = 0;
            arr_row[k]  = '0;
            for (int c = 0; c < SYS_COL; c++) sch_d[k][c] = $urandom();
        end
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        exp_ovf  = 1'b0;
        exp_skew = 1'b0;
        tile_pos = 0;
        cfg_rows = 16'd1;
        en_in    = '0;
        row_bus.out_ready = 1'b0;
        for (int c = 0; c < SYS_COL; c++) psum_in[c] = '0;

        // Reset state.
        rst_now = 1'b1;
        run(3);
        rst_now = 1'b0;
        check_idle_zero("reset");

        // Single row c+1, one-row tiles: valid exactly SYS_COL cycles after column 0.
        cfg_rows = 16'd1;
        for (int c = 0; c < SYS_COL; c++) row_buf[c] = psum_t'(c + 1);
        launch(cyc + 1, -1);
        run(22);

        // Eight back-to-back rows in tiles of four.
        cfg_rows = 16'd4;
        s = cyc;
        for (int i = 0; i < 8; i++) begin
            rand_row();
            launch(s + i, -1);
        end
        run(34);

        // Fill the FIFO with the consumer stalled, refill on a same-cycle pop,
        // then overflow it and drain.
        cfg_rows = 16'd3;
        s = cyc;
        set_rdy(s, 60, 1'b0);
        sch_rdy[s+25] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_row();
            launch(s + i, -1);
        end
        rand_row();
        launch(s + 10, -1);
        rand_row();
        launch(s + 12, -1);
        run(80);

        // Broken row (column 3 withheld) between two good rows.
        cfg_rows = 16'd2;
        s = cyc;
        rand_row();
        launch(s, -1);
        rand_row();
        launch(s + 1, 3);
        rand_row();
        launch(s + 2, -1);
        run(26);

        // Reset with three rows buffered and two still in the de-skew pipeline.
        s = cyc;
        set_rdy(s, 30, 1'b0);
        for (int i = 0; i < 3; i++) begin
            rand_row();
            launch(s + i, -1);
        end
        for (int i = 8; i < 10; i++) begin
            rand_row();
            launch(s + i, -1);
        end
        run(19);
        rst_now = 1'b1;
        run(1);
        rst_now = 1'b0;
        run(30);
        check_idle_zero("post_reset");

        // Negative sum in column 0.
        cfg_rows = 16'd1;
        rand_row();
        row_buf[0] = 32'hFFFF_FFFB;
        launch(cyc, -1);
        run(20);

        // Randomised traffic: ragged gaps, stalls, occasional broken rows.
        random_round(250, 0);
        random_round(250, int'($urandom_range(1, 5)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
